// File: rtl/rs_pkg.sv
// Shared types and constants for the reservation-station status array and its entries.
// The optional performance counters are built only when RS_PERF_CNT_EN is defined.
package rs_pkg;

   localparam int NUM_ENTRY_DEF  = 8;
   localparam int PREG_W         = 6;
   localparam int DATA_W         = 16;
   localparam int REPLAY_CYC_DEF = 3;
   localparam int RCNT_W         = 4;   // holds REPLAY_CYC - 1, so REPLAY_CYC may go up to 16
   localparam int PERF_W         = 16;

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_WAIT   = 2'd1,
      ST_SCHED  = 2'd2,
      ST_REPLAY = 2'd3
   } entry_state_e;

   typedef struct packed {
      logic [1:0][PREG_W-1:0] psrc;
      logic [1:0]             src_rdy;
      logic [DATA_W-1:0]      data;
   } rs_entry_t;

   function automatic logic tag_hit(input logic [PREG_W-1:0]      tag,
                                    input logic [1:0]             wk_valid,
                                    input logic [1:0][PREG_W-1:0] wk_pdest);
      return (wk_valid[0] && (wk_pdest[0] == tag)) || (wk_valid[1] && (wk_pdest[1] == tag));
   endfunction

   function automatic logic [PERF_W-1:0] sat_add(input logic [PERF_W-1:0] a,
                                                 input logic [1:0]        inc);
      logic [PERF_W:0] sum;
      sum = {1'b0, a} + {{(PERF_W-1){1'b0}}, inc};
      return sum[PERF_W] ? {PERF_W{1'b1}} : sum[PERF_W-1:0];
   endfunction

endpackage

// File: rtl/rs_status_entry.sv
// One reservation-station slot: lifecycle FSM, source wakeup and replay countdown.
// With RS_PERF_CNT_EN defined it also reports when a replay is accepted.
module rs_status_entry
   import rs_pkg::*;
#(
   parameter int REPLAY_CYC = REPLAY_CYC_DEF
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   enq_en,
   input  rs_entry_t              enq_entry,
   input  logic [1:0]             wk_valid,
   input  logic [1:0][PREG_W-1:0] wk_pdest,
   input  logic                   grant,
   input  logic                   fb_en,
   input  logic                   fb_hit,
`ifdef RS_PERF_CNT_EN
   output logic                   replay_start,
`endif
   output logic                   valid,
   output logic                   request,
   output logic [DATA_W-1:0]      data
);

   entry_state_e      state_reg, state_next;
   logic [RCNT_W-1:0] cnt_reg, cnt_next;
   rs_entry_t         ent_reg, ent_next;

   assign valid   = (state_reg != ST_EMPTY);
   assign request = (state_reg == ST_WAIT) && (&ent_reg.src_rdy);
   assign data    = ent_reg.data;

`ifdef RS_PERF_CNT_EN
   assign replay_start = (state_reg == ST_SCHED) && fb_en && !fb_hit && !enq_en && !flush;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_EMPTY;
         cnt_reg   <= '0;
         ent_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         ent_reg   <= ent_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      ent_next   = ent_reg;

      if (state_reg != ST_EMPTY) begin
         for (int i = 0; i < 2; i++) begin
            if (tag_hit(ent_reg.psrc[i], wk_valid, wk_pdest)) ent_next.src_rdy[i] = 1'b1;
         end
      end

      case (state_reg)
         ST_WAIT: begin
            if (grant && request) state_next = ST_SCHED;
         end
         ST_SCHED: begin
            if (fb_en) begin
               if (fb_hit) begin
                  state_next = ST_EMPTY;
               end else if (REPLAY_CYC == 1) begin
                  state_next = ST_WAIT;
               end else begin
                  state_next = ST_REPLAY;
                  cnt_next   = RCNT_W'(REPLAY_CYC - 1);
               end
            end
         end
         ST_REPLAY: begin
            // Leave as the counter reaches zero so the request returns REPLAY_CYC cycles after feedback.
            cnt_next = cnt_reg - RCNT_W'(1);
            if (cnt_reg <= RCNT_W'(1)) begin
               state_next = ST_WAIT;
               cnt_next   = '0;
            end
         end
         default: ;
      endcase

      if (enq_en) begin
         state_next = ST_WAIT;
         ent_next   = enq_entry;
         cnt_next   = '0;
      end

      if (flush) begin
         state_next = ST_EMPTY;
         cnt_next   = '0;
      end
   end

endmodule

// File: rtl/rs_status_array.sv
// Status store for an 8-entry reservation station: enqueue, wakeup, request, grant and replay.
// Define RS_PERF_CNT_EN to add saturating enqueue/issue/replay counters.
module rs_status_array
   import rs_pkg::*;
#(
   parameter int NUM_ENTRY  = NUM_ENTRY_DEF,
   parameter int REPLAY_CYC = REPLAY_CYC_DEF
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 io_flush,
   input  logic                 io_enq_0_valid,
   input  logic [NUM_ENTRY-1:0] io_enq_0_alloc,
   input  logic [PREG_W-1:0]    io_enq_0_psrc0,
   input  logic [PREG_W-1:0]    io_enq_0_psrc1,
   input  logic [1:0]           io_enq_0_srcRdy,
   input  logic [DATA_W-1:0]    io_enq_0_data,
   input  logic                 io_enq_1_valid,
   input  logic [NUM_ENTRY-1:0] io_enq_1_alloc,
   input  logic [PREG_W-1:0]    io_enq_1_psrc0,
   input  logic [PREG_W-1:0]    io_enq_1_psrc1,
   input  logic [1:0]           io_enq_1_srcRdy,
   input  logic [DATA_W-1:0]    io_enq_1_data,
   output logic                 io_enq_1_ready,
   input  logic                 io_wakeup_0_valid,
   input  logic [PREG_W-1:0]    io_wakeup_0_pdest,
   input  logic                 io_wakeup_1_valid,
   input  logic [PREG_W-1:0]    io_wakeup_1_pdest,
   output logic [NUM_ENTRY-1:0] io_validVec,
   output logic [NUM_ENTRY-1:0] io_request,
   input  logic                 io_grant_valid,
   input  logic [NUM_ENTRY-1:0] io_grant_bits,
   output logic [DATA_W-1:0]    io_issue_data,
   input  logic                 io_fb_valid,
   input  logic [NUM_ENTRY-1:0] io_fb_idx,
`ifdef RS_PERF_CNT_EN
   output logic [PERF_W-1:0]    io_perf_enq,
   output logic [PERF_W-1:0]    io_perf_issue,
   output logic [PERF_W-1:0]    io_perf_replay,
`endif
   input  logic                 io_fb_hit
);

   logic [1:0]             wk_valid;
   logic [1:0][PREG_W-1:0] wk_pdest;
   rs_entry_t              enq_pkt [2];
   logic [NUM_ENTRY-1:0]   valid_vec;
   logic [NUM_ENTRY-1:0]   request_vec;
   logic [DATA_W-1:0]      entry_data [NUM_ENTRY];
`ifdef RS_PERF_CNT_EN
   logic [NUM_ENTRY-1:0]   replay_vec;
`endif

   assign wk_valid = {io_wakeup_1_valid, io_wakeup_0_valid};
   assign wk_pdest = {io_wakeup_1_pdest, io_wakeup_0_pdest};

   // Sources woken in the enqueue cycle are captured as ready (same-cycle bypass).
   always_comb begin
      enq_pkt[0].psrc    = {io_enq_0_psrc1, io_enq_0_psrc0};
      enq_pkt[0].src_rdy = io_enq_0_srcRdy;
      enq_pkt[0].data    = io_enq_0_data;
      enq_pkt[1].psrc    = {io_enq_1_psrc1, io_enq_1_psrc0};
      enq_pkt[1].src_rdy = io_enq_1_srcRdy;
      enq_pkt[1].data    = io_enq_1_data;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 2; i++) begin
            if (tag_hit(enq_pkt[k].psrc[i], wk_valid, wk_pdest)) enq_pkt[k].src_rdy[i] = 1'b1;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_ENTRY; gi++) begin : g_entry
         logic en0, en1;
         assign en0 = io_enq_0_valid && io_enq_0_alloc[gi];
         assign en1 = io_enq_1_valid && io_enq_1_alloc[gi];

         rs_status_entry #(
            .REPLAY_CYC(REPLAY_CYC)
         ) u_entry (
            .clock       (clock),
            .reset       (reset),
            .flush       (io_flush),
            .enq_en      (en0 || en1),
            .enq_entry   (en0 ? enq_pkt[0] : enq_pkt[1]),
            .wk_valid    (wk_valid),
            .wk_pdest    (wk_pdest),
            .grant       (io_grant_valid && io_grant_bits[gi]),
            .fb_en       (io_fb_valid && io_fb_idx[gi]),
            .fb_hit      (io_fb_hit),
`ifdef RS_PERF_CNT_EN
            .replay_start(replay_vec[gi]),
`endif
            .valid       (valid_vec[gi]),
            .request     (request_vec[gi]),
            .data        (entry_data[gi])
         );
      end
   endgenerate

   assign io_validVec    = valid_vec;
   assign io_request     = request_vec;
   assign io_enq_1_ready = ($countones(~valid_vec) >= 2);

   always_comb begin
      io_issue_data = '0;
      if (!io_flush) begin
         for (int e = 0; e < NUM_ENTRY; e++) begin
            if (io_grant_valid && io_grant_bits[e] && request_vec[e]) io_issue_data |= entry_data[e];
         end
      end
   end

`ifdef RS_PERF_CNT_EN
   logic       enq0_fire, enq1_fire, issue_fire, replay_fire;
   logic [1:0] enq_inc;

   // Port 1 counts only for slots that port 0 did not claim in the same cycle.
   assign enq0_fire   = !io_flush && io_enq_0_valid && (|io_enq_0_alloc);
   assign enq1_fire   = !io_flush && io_enq_1_valid &&
                        (|(io_enq_1_alloc & ~(io_enq_0_valid ? io_enq_0_alloc : '0)));
   assign enq_inc     = {1'b0, enq0_fire} + {1'b0, enq1_fire};
   assign issue_fire  = !io_flush && io_grant_valid && (|(io_grant_bits & request_vec));
   assign replay_fire = |replay_vec;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         io_perf_enq    <= '0;
         io_perf_issue  <= '0;
         io_perf_replay <= '0;
      end else begin
         io_perf_enq    <= sat_add(io_perf_enq, enq_inc);
         io_perf_issue  <= sat_add(io_perf_issue, {1'b0, issue_fire});
         io_perf_replay <= sat_add(io_perf_replay, {1'b0, replay_fire});
      end
   end
`endif

endmodule

// File: tb/tb_rs_status_array.sv
// Scoreboard bench for rs_status_array: directed scenarios plus random traffic vs. a slot-level model.
module tb_rs_status_array;
   import rs_pkg::*;

   localparam int NE = 8;
   localparam int RC = 3;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        io_flush;
   logic        io_enq_0_valid, io_enq_1_valid;
   logic [7:0]  io_enq_0_alloc, io_enq_1_alloc;
   logic [5:0]  io_enq_0_psrc0, io_enq_0_psrc1, io_enq_1_psrc0, io_enq_1_psrc1;
   logic [1:0]  io_enq_0_srcRdy, io_enq_1_srcRdy;
   logic [15:0] io_enq_0_data, io_enq_1_data;
   logic        io_enq_1_ready;
   logic        io_wakeup_0_valid, io_wakeup_1_valid;
   logic [5:0]  io_wakeup_0_pdest, io_wakeup_1_pdest;
   logic [7:0]  io_validVec, io_request;
   logic        io_grant_valid;
   logic [7:0]  io_grant_bits;
   logic [15:0] io_issue_data;
   logic        io_fb_valid;
   logic [7:0]  io_fb_idx;
   logic        io_fb_hit;
`ifdef RS_PERF_CNT_EN
   logic [15:0] io_perf_enq, io_perf_issue, io_perf_replay;
`endif

   always #5 clock = ~clock;

   rs_status_array #(.NUM_ENTRY(NE), .REPLAY_CYC(RC)) dut (
      .clock(clock), .reset(reset), .io_flush(io_flush),
      .io_enq_0_valid(io_enq_0_valid), .io_enq_0_alloc(io_enq_0_alloc),
      .io_enq_0_psrc0(io_enq_0_psrc0), .io_enq_0_psrc1(io_enq_0_psrc1),
      .io_enq_0_srcRdy(io_enq_0_srcRdy), .io_enq_0_data(io_enq_0_data),
      .io_enq_1_valid(io_enq_1_valid), .io_enq_1_alloc(io_enq_1_alloc),
      .io_enq_1_psrc0(io_enq_1_psrc0), .io_enq_1_psrc1(io_enq_1_psrc1),
      .io_enq_1_srcRdy(io_enq_1_srcRdy), .io_enq_1_data(io_enq_1_data),
      .io_enq_1_ready(io_enq_1_ready),
      .io_wakeup_0_valid(io_wakeup_0_valid), .io_wakeup_0_pdest(io_wakeup_0_pdest),
      .io_wakeup_1_valid(io_wakeup_1_valid), .io_wakeup_1_pdest(io_wakeup_1_pdest),
      .io_validVec(io_validVec), .io_request(io_request),
      .io_grant_valid(io_grant_valid), .io_grant_bits(io_grant_bits),
      .io_issue_data(io_issue_data),
      .io_fb_valid(io_fb_valid), .io_fb_idx(io_fb_idx),
`ifdef RS_PERF_CNT_EN
      .io_perf_enq(io_perf_enq), .io_perf_issue(io_perf_issue), .io_perf_replay(io_perf_replay),
`endif
      .io_fb_hit(io_fb_hit)
   );

   typedef struct {
      bit flush;
      bit e0_v; logic [7:0] e0_alloc; logic [5:0] e0_ps0, e0_ps1; logic [1:0] e0_rdy; logic [15:0] e0_data;
      bit e1_v; logic [7:0] e1_alloc; logic [5:0] e1_ps0, e1_ps1; logic [1:0] e1_rdy; logic [15:0] e1_data;
      bit w0_v; logic [5:0] w0_p;
      bit w1_v; logic [5:0] w1_p;
      bit g_v; logic [7:0] g_bits;
      bit f_v; logic [7:0] f_idx; bit f_hit;
   } stim_t;

   typedef struct {
      logic [7:0]  vv;
      logic [7:0]  req;
      logic        rdy1;
      logic [15:0] issue;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   // Slot-level reference: occupancy, awaiting-feedback flag, earliest cycle it may request again.
   bit          m_valid [NE];
   bit          m_sched [NE];
   bit          m_rdy   [NE][2];
   logic [5:0]  m_psrc  [NE][2];
   logic [15:0] m_data  [NE];
   int          m_ready_at [NE];
   int          cyc = 0;

   function automatic bit m_req(int e);
      return m_valid[e] && m_rdy[e][0] && m_rdy[e][1] && !m_sched[e] && (cyc >= m_ready_at[e]);
   endfunction

   function automatic int oh_idx(logic [7:0] v);
      for (int e = 0; e < NE; e++) if (v[e]) return e;
      return -1;
   endfunction

   function automatic bit woke(logic [5:0] t, stim_t s);
      return (s.w0_v && s.w0_p == t) || (s.w1_v && s.w1_p == t);
   endfunction

   function automatic stim_t idle_s();
      stim_t s;
      s = '{default: 0};
      return s;
   endfunction

   task automatic model_reset();
      for (int e = 0; e < NE; e++) begin
         m_valid[e] = 0; m_sched[e] = 0; m_rdy[e][0] = 0; m_rdy[e][1] = 0;
         m_psrc[e][0] = '0; m_psrc[e][1] = '0; m_data[e] = '0; m_ready_at[e] = 0;
      end
   endtask

   task automatic install(int port, stim_t s);
      int e;
      logic [5:0] p0, p1; logic [1:0] r; logic [15:0] d;
      e  = oh_idx(port == 0 ? s.e0_alloc : s.e1_alloc);
      p0 = port == 0 ? s.e0_ps0 : s.e1_ps0;
      p1 = port == 0 ? s.e0_ps1 : s.e1_ps1;
      r  = port == 0 ? s.e0_rdy : s.e1_rdy;
      d  = port == 0 ? s.e0_data : s.e1_data;
      if (e < 0) return;
      m_valid[e] = 1; m_sched[e] = 0; m_ready_at[e] = 0;
      m_psrc[e][0] = p0; m_psrc[e][1] = p1; m_data[e] = d;
      m_rdy[e][0] = r[0] || woke(p0, s);
      m_rdy[e][1] = r[1] || woke(p1, s);
   endtask

   task automatic chk(string name, int c, logic [15:0] act, logic [15:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", name, c, act, expv);
      end
   endtask

   task automatic drive_cycle(stim_t s);
      exp_t x;
      int g, f, nfree;
      bit req_now [NE];
      @(posedge clock); #1;
      io_flush = s.flush;
      io_enq_0_valid = s.e0_v; io_enq_0_alloc = s.e0_alloc; io_enq_0_psrc0 = s.e0_ps0;
      io_enq_0_psrc1 = s.e0_ps1; io_enq_0_srcRdy = s.e0_rdy; io_enq_0_data = s.e0_data;
      io_enq_1_valid = s.e1_v; io_enq_1_alloc = s.e1_alloc; io_enq_1_psrc0 = s.e1_ps0;
      io_enq_1_psrc1 = s.e1_ps1; io_enq_1_srcRdy = s.e1_rdy; io_enq_1_data = s.e1_data;
      io_wakeup_0_valid = s.w0_v; io_wakeup_0_pdest = s.w0_p;
      io_wakeup_1_valid = s.w1_v; io_wakeup_1_pdest = s.w1_p;
      io_grant_valid = s.g_v; io_grant_bits = s.g_bits;
      io_fb_valid = s.f_v; io_fb_idx = s.f_idx; io_fb_hit = s.f_hit;

      nfree = 0;
      for (int e = 0; e < NE; e++) begin
         x.vv[e]    = m_valid[e];
         x.req[e]   = m_req(e);
         req_now[e] = m_req(e);
         if (!m_valid[e]) nfree++;
      end
      x.rdy1  = (nfree >= 2);
      g       = oh_idx(s.g_bits);
      x.issue = (!s.flush && s.g_v && g >= 0 && req_now[g]) ? m_data[g] : 16'h0;
      x.cyc   = cyc;
      exp_q.push_back(x);

      if (s.flush) begin
         for (int e = 0; e < NE; e++) begin
            m_valid[e] = 0; m_sched[e] = 0; m_ready_at[e] = 0;
         end
      end else begin
         for (int e = 0; e < NE; e++)
            if (m_valid[e])
               for (int i = 0; i < 2; i++) if (woke(m_psrc[e][i], s)) m_rdy[e][i] = 1;
         f = oh_idx(s.f_idx);
         if (s.f_v && f >= 0 && m_sched[f]) begin
            m_sched[f] = 0;
            if (s.f_hit) m_valid[f] = 0;
            else m_ready_at[f] = cyc + RC;
         end
         if (s.g_v && g >= 0 && req_now[g]) m_sched[g] = 1;
         if (s.e1_v) install(1, s);
         if (s.e0_v) install(0, s);
      end
      cyc++;
   endtask

   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         exp_t x;
         x = exp_q.pop_front();
         chk("validVec", x.cyc, {8'h0, io_validVec}, {8'h0, x.vv});
         chk("request",  x.cyc, {8'h0, io_request},  {8'h0, x.req});
         chk("enq1_rdy", x.cyc, {15'h0, io_enq_1_ready}, {15'h0, x.rdy1});
         chk("issue",    x.cyc, io_issue_data, x.issue);
         $display("txn cyc=%0d vv=%h req=%h rdy1=%b issue=%h", x.cyc, io_validVec, io_request,
                  io_enq_1_ready, io_issue_data);
      end
   end

   function automatic logic [7:0] pick_oh(logic [7:0] v);
      int c[$];
      for (int e = 0; e < NE; e++) if (v[e]) c.push_back(e);
      if (c.size() == 0) return 8'(1 << $urandom_range(0, NE - 1));
      return 8'(1 << c[$urandom_range(0, c.size() - 1)]);
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      logic [7:0] free_v, req_v, sched_v;
      s = idle_s();
      for (int e = 0; e < NE; e++) begin
         free_v[e] = !m_valid[e]; req_v[e] = m_req(e); sched_v[e] = m_sched[e];
      end
      s.flush   = ($urandom_range(0, 99) == 0);
      s.e0_v    = ($urandom_range(0, 1) == 1);
      s.e0_alloc = pick_oh(free_v);
      s.e0_ps0 = 6'($urandom_range(0, 7)); s.e0_ps1 = 6'($urandom_range(0, 7));
      s.e0_rdy = 2'($urandom_range(0, 3)); s.e0_data = 16'($urandom);
      s.e1_v    = ($urandom_range(0, 2) == 0);
      s.e1_alloc = pick_oh(free_v & ~(s.e0_v ? s.e0_alloc : 8'h0));
      s.e1_ps0 = 6'($urandom_range(0, 7)); s.e1_ps1 = 6'($urandom_range(0, 7));
      s.e1_rdy = 2'($urandom_range(0, 3)); s.e1_data = 16'($urandom);
      s.w0_v = ($urandom_range(0, 1) == 1); s.w0_p = 6'($urandom_range(0, 7));
      s.w1_v = ($urandom_range(0, 1) == 1); s.w1_p = 6'($urandom_range(0, 7));
      s.g_v  = ($urandom_range(0, 2) != 0); s.g_bits = pick_oh(req_v);
      s.f_v  = ($urandom_range(0, 1) == 1); s.f_idx = pick_oh(sched_v);
      s.f_hit = ($urandom_range(0, 1) == 1);
      return s;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      stim_t s;
      io_flush = 0; io_enq_0_valid = 0; io_enq_0_alloc = 0; io_enq_0_psrc0 = 0; io_enq_0_psrc1 = 0;
      io_enq_0_srcRdy = 0; io_enq_0_data = 0; io_enq_1_valid = 0; io_enq_1_alloc = 0;
      io_enq_1_psrc0 = 0; io_enq_1_psrc1 = 0; io_enq_1_srcRdy = 0; io_enq_1_data = 0;
      io_wakeup_0_valid = 0; io_wakeup_0_pdest = 0; io_wakeup_1_valid = 0; io_wakeup_1_pdest = 0;
      io_grant_valid = 0; io_grant_bits = 0; io_fb_valid = 0; io_fb_idx = 0; io_fb_hit = 0;
      model_reset();

      #2 reset = 1'b0;
      #1;
      chk("rst_validVec", -1, {8'h0, io_validVec}, 16'h0);
      chk("rst_request",  -1, {8'h0, io_request},  16'h0);
      chk("rst_issue",    -1, io_issue_data, 16'h0);
      repeat (2) @(posedge clock);
      @(negedge clock) reset = 1'b1;

      // Enqueue ready, grant, replay after miss, then retire on hit.
      s = idle_s(); s.e0_v = 1; s.e0_alloc = 8'h08; s.e0_rdy = 2'b11; s.e0_data = 16'hABCD;
      drive_cycle(s);
      s = idle_s(); s.g_v = 1; s.g_bits = 8'h08; drive_cycle(s);
      drive_cycle(idle_s());
      s = idle_s(); s.f_v = 1; s.f_idx = 8'h08; s.f_hit = 0; drive_cycle(s);
      repeat (3) drive_cycle(idle_s());
      s = idle_s(); s.g_v = 1; s.g_bits = 8'h08; drive_cycle(s);
      s = idle_s(); s.f_v = 1; s.f_idx = 8'h08; s.f_hit = 1; drive_cycle(s);
      drive_cycle(idle_s());

      // Wakeup later, then wakeup bypassed in the enqueue cycle.
      s = idle_s(); s.e0_v = 1; s.e0_alloc = 8'h01; s.e0_ps0 = 6'd5; s.e0_ps1 = 6'd9;
      s.e0_rdy = 2'b10; s.e0_data = 16'h1111; drive_cycle(s);
      repeat (2) drive_cycle(idle_s());
      s = idle_s(); s.w1_v = 1; s.w1_p = 6'd5; drive_cycle(s);
      drive_cycle(idle_s());
      s = idle_s(); s.e0_v = 1; s.e0_alloc = 8'h02; s.e0_ps0 = 6'd5; s.e0_ps1 = 6'd9;
      s.e0_rdy = 2'b10; s.e0_data = 16'h2222; s.w1_v = 1; s.w1_p = 6'd5; drive_cycle(s);
      drive_cycle(idle_s());

      // Fill seven slots, collide both ports on the last one, read it back via grant.
      s = idle_s(); s.flush = 1; drive_cycle(s);
      for (int e = 0; e < NE; e++) begin
         if (e == 4) continue;
         s = idle_s(); s.e0_v = 1; s.e0_alloc = 8'(1 << e); s.e0_rdy = 2'b11;
         s.e0_data = 16'(16'h3000 + e); drive_cycle(s);
      end
      s = idle_s(); s.e0_v = 1; s.e0_alloc = 8'h10; s.e0_rdy = 2'b11; s.e0_data = 16'h4444;
      s.e1_v = 1; s.e1_alloc = 8'h10; s.e1_rdy = 2'b11; s.e1_data = 16'h5555; drive_cycle(s);
      s = idle_s(); s.g_v = 1; s.g_bits = 8'h10; drive_cycle(s);

      // Flush wins over a same-cycle enqueue and grant.
      s = idle_s(); s.flush = 1; s.e0_v = 1; s.e0_alloc = 8'h10; s.e0_rdy = 2'b11;
      s.e0_data = 16'h6666; s.g_v = 1; s.g_bits = 8'h01; drive_cycle(s);
      drive_cycle(idle_s());

      for (int n = 0; n < 600; n++) drive_cycle(rand_stim());

      // Asynchronous reset in the middle of a replay countdown.
      s = idle_s(); s.flush = 1; drive_cycle(s);
      s = idle_s(); s.e0_v = 1; s.e0_alloc = 8'h01; s.e0_rdy = 2'b11; s.e0_data = 16'h7777;
      drive_cycle(s);
      s = idle_s(); s.g_v = 1; s.g_bits = 8'h01; drive_cycle(s);
      s = idle_s(); s.f_v = 1; s.f_idx = 8'h01; s.f_hit = 0; drive_cycle(s);
      drive_cycle(idle_s());
      @(negedge clock); #2;
      reset = 1'b0;
      #1;
      chk("arst_validVec", cyc, {8'h0, io_validVec}, 16'h0);
      chk("arst_request",  cyc, {8'h0, io_request},  16'h0);
      chk("arst_issue",    cyc, io_issue_data, 16'h0);
      model_reset();
      @(negedge clock) reset = 1'b1;
      repeat (4) drive_cycle(idle_s());

      @(negedge clock); @(negedge clock);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
